// File: rtl/blit_scheduler.sv
// blit_scheduler: per-frame draw-list sequencer issuing one-sprite blit commands over a start/done handshake.
module blit_scheduler #(
  parameter int SCREEN_WIDTH     = 320,
  parameter int SCREEN_HEIGHT    = 180,
  parameter int SPRITE_SIZE      = 32,
  parameter int MAX_FAILHOLE_NUM = 7,
  parameter int SPRITE_BG_INDEX  = 0,
  parameter int SPRITE_BL_INDEX  = 1,
  parameter int SPRITE_FH_INDEX  = 2,
  parameter int SPRITE_WH_INDEX  = 3,
  parameter int SPRITE_SEL_INDEX = 6
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic                          i_frame_start,
  input  logic [9:0]                    i_bl_x,
  input  logic [9:0]                    i_bl_y,
  input  logic [9:0]                    i_wh_pos_x,
  input  logic [9:0]                    i_wh_pos_y,
  input  logic [10*MAX_FAILHOLE_NUM-1:0] i_fh_pos_x,
  input  logic [10*MAX_FAILHOLE_NUM-1:0] i_fh_pos_y,
  input  logic                          i_overlay_en,
  input  logic [4:0]                    i_overlay_index,
  input  logic [2:0]                    i_select_pos,
  input  logic                          i_blit_done,
  output logic                          o_blit_start,
  output logic [9:0]                    o_blit_x,
  output logic [9:0]                    o_blit_y,
  output logic [4:0]                    o_blit_sprite,
  output logic                          o_blit_transparent,
  output logic                          o_busy,
  output logic                          o_frame_done,
  output logic [7:0]                    o_overrun_cnt
);
  localparam int FHW = (MAX_FAILHOLE_NUM > 1) ? $clog2(MAX_FAILHOLE_NUM) : 1;
  localparam int COLS = (SCREEN_WIDTH + SPRITE_SIZE - 1) / SPRITE_SIZE;
  localparam int ROWS = (SCREEN_HEIGHT + SPRITE_SIZE - 1) / SPRITE_SIZE;
  localparam logic [9:0] STEP   = 10'(SPRITE_SIZE);
  localparam logic [9:0] LAST_X = 10'((COLS - 1) * SPRITE_SIZE);
  localparam logic [9:0] LAST_Y = 10'((ROWS - 1) * SPRITE_SIZE);
  localparam logic [9:0] OVL_X  = 10'((SCREEN_WIDTH - SPRITE_SIZE) / 2);
  localparam logic [9:0] OVL_Y  = 10'((SCREEN_HEIGHT - SPRITE_SIZE) / 2);
  localparam logic [9:0] SEL_X  = OVL_X - STEP;

  typedef enum logic [2:0] {IDLE, BG, FH, WH, BL, OVL, SEL, DONE} state_t;

  state_t r_state, w_next, w_after;
  logic r_wait, r_pend, r_ovl_en;
  logic [9:0] r_tx, r_ty, r_bl_x, r_bl_y, r_wh_x, r_wh_y;
  logic [10*MAX_FAILHOLE_NUM-1:0] r_fh_x, r_fh_y;
  logic [FHW-1:0] r_fh;
  logic [4:0] r_ovl_idx;
  logic [2:0] r_sel;
  logic [7:0] r_ovr;
  logic w_draw, w_adv, w_last, w_busy, w_snap, w_issue, w_tr;
  logic [9:0] w_x, w_y;
  logic [4:0] w_spr;

  assign w_draw  = r_state != IDLE && r_state != DONE;
  assign w_adv   = r_wait && i_blit_done;
  assign w_issue = w_draw && !r_wait;
  assign w_last  = (r_state == BG) ? (r_tx == LAST_X && r_ty == LAST_Y) :
                   (r_state == FH) ? (r_fh == FHW'(MAX_FAILHOLE_NUM - 1)) : 1'b1;
  assign w_busy  = w_draw || (r_state == DONE && r_pend);
  // a request seen in DONE with nothing queued starts the next pass directly
  assign w_snap  = (r_state == IDLE || r_state == DONE) && (i_frame_start || r_pend);

  assign o_busy        = w_busy;
  assign o_frame_done  = r_state == DONE;
  assign o_overrun_cnt = r_ovr;

  always_comb begin
    w_after = DONE;
    w_x = '0;
    w_y = '0;
    w_spr = '0;
    w_tr = 1'b1;
    case (r_state)
      BG:  begin w_after = FH; w_x = r_tx; w_y = r_ty; w_spr = 5'(SPRITE_BG_INDEX); w_tr = 1'b0; end
      FH:  begin w_after = WH; w_x = r_fh_x[9:0]; w_y = r_fh_y[9:0]; w_spr = 5'(SPRITE_FH_INDEX); end
      WH:  begin w_after = BL; w_x = r_wh_x; w_y = r_wh_y; w_spr = 5'(SPRITE_WH_INDEX); end
      BL:  begin w_after = r_ovl_en ? OVL : DONE; w_x = r_bl_x; w_y = r_bl_y; w_spr = 5'(SPRITE_BL_INDEX); end
      OVL: begin w_after = SEL; w_x = OVL_X; w_y = OVL_Y; w_spr = r_ovl_idx; end
      SEL: begin w_after = DONE; w_x = SEL_X; w_y = OVL_Y + {4'b0, r_sel, 3'b0}; w_spr = 5'(SPRITE_SEL_INDEX); end
      default: ;
    endcase
    w_next = w_draw ? ((w_adv && w_last) ? w_after : r_state) : (w_snap ? BG : IDLE);
  end

  always_ff @(posedge CLK) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      o_blit_start <= 1'b0;
      o_blit_x <= '0;
      o_blit_y <= '0;
      o_blit_sprite <= '0;
      o_blit_transparent <= 1'b0;
      r_wait <= 1'b0;
      r_pend <= 1'b0;
      r_ovr <= '0;
      r_tx <= '0;
      r_ty <= '0;
      r_fh <= '0;
      r_bl_x <= '0;
      r_bl_y <= '0;
      r_wh_x <= '0;
      r_wh_y <= '0;
      r_fh_x <= '0;
      r_fh_y <= '0;
      r_ovl_en <= 1'b0;
      r_ovl_idx <= '0;
      r_sel <= '0;
    end else begin
      o_blit_start <= w_issue;
      if (w_issue) begin
        r_wait <= 1'b1;
        o_blit_x <= w_x;
        o_blit_y <= w_y;
        o_blit_sprite <= w_spr;
        o_blit_transparent <= w_tr;
      end
      if (w_adv) r_wait <= 1'b0;
      if (w_adv && r_state == BG) begin
        r_tx <= (r_tx == LAST_X) ? '0 : r_tx + STEP;
        r_ty <= (r_tx == LAST_X) ? r_ty + STEP : r_ty;
      end
      // hole buses are consumed from the bottom so the current hole is always bits [9:0]
      if (w_adv && r_state == FH) begin
        r_fh <= r_fh + FHW'(1);
        r_fh_x <= r_fh_x >> 10;
        r_fh_y <= r_fh_y >> 10;
      end
      if (w_snap) begin
        r_tx <= '0;
        r_ty <= '0;
        r_fh <= '0;
        r_bl_x <= i_bl_x;
        r_bl_y <= i_bl_y;
        r_wh_x <= i_wh_pos_x;
        r_wh_y <= i_wh_pos_y;
        r_fh_x <= i_fh_pos_x;
        r_fh_y <= i_fh_pos_y;
        r_ovl_en <= i_overlay_en;
        r_ovl_idx <= i_overlay_index;
        r_sel <= i_select_pos;
      end
      r_pend <= (r_state == DONE) ? (r_pend && i_frame_start) : (r_pend || (i_frame_start && w_busy));
      if (i_frame_start && w_busy && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
    end
  end
endmodule

// File: tb/tb_blit_scheduler.sv
// tb_blit_scheduler: vector table, hand-written corner sequences and randomized passes against a draw-list model.
module tb_blit_scheduler;
  localparam int N = 7;
  logic CLK = 1'b0;
  logic rst = 1'b1;
  logic i_frame_start = 1'b0;
  logic [9:0] i_bl_x = '0, i_bl_y = '0, i_wh_pos_x = '0, i_wh_pos_y = '0;
  logic [10*N-1:0] i_fh_pos_x = '0, i_fh_pos_y = '0;
  logic i_overlay_en = 1'b0;
  logic [4:0] i_overlay_index = '0;
  logic [2:0] i_select_pos = '0;
  logic i_blit_done = 1'b0;
  logic o_blit_start, o_blit_transparent, o_busy, o_frame_done;
  logic [9:0] o_blit_x, o_blit_y;
  logic [4:0] o_blit_sprite;
  logic [7:0] o_overrun_cnt;

  blit_scheduler dut (
    .CLK(CLK), .rst(rst), .i_frame_start(i_frame_start),
    .i_bl_x(i_bl_x), .i_bl_y(i_bl_y), .i_wh_pos_x(i_wh_pos_x), .i_wh_pos_y(i_wh_pos_y),
    .i_fh_pos_x(i_fh_pos_x), .i_fh_pos_y(i_fh_pos_y),
    .i_overlay_en(i_overlay_en), .i_overlay_index(i_overlay_index), .i_select_pos(i_select_pos),
    .i_blit_done(i_blit_done), .o_blit_start(o_blit_start), .o_blit_x(o_blit_x), .o_blit_y(o_blit_y),
    .o_blit_sprite(o_blit_sprite), .o_blit_transparent(o_blit_transparent),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_overrun_cnt(o_overrun_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic [9:0] x; logic [9:0] y; logic [4:0] spr; logic tr;} cmd_t;
  typedef struct packed {
    logic [9:0] bl_x, bl_y, wh_x, wh_y;
    logic [10*N-1:0] fh_x, fh_y;
    logic ovl;
    logic [4:0] idx;
    logic [2:0] sel;
  } cfg_t;
  typedef struct {cfg_t c; int n; cmd_t last; cmd_t h0;} vec_t;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_done = 0, frames = 0, starts = 0, cnt = -1, blit_delay = 3;
  cmd_t held, cur;
  cmd_t cap_q[$], exp_q[$];
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic cmd_t mk(input int x, input int y, input int s, input logic t);
    cmd_t m;
    m.x = 10'(x);
    m.y = 10'(y);
    m.spr = 5'(s);
    m.tr = t;
    return m;
  endfunction

  function automatic cfg_t mkcfg(input int blx, input int bly, input int whx, input int why,
                                 input int seed, input logic ovl, input int idx, input int sel);
    cfg_t c;
    c.bl_x = 10'(blx); c.bl_y = 10'(bly); c.wh_x = 10'(whx); c.wh_y = 10'(why);
    for (int i = 0; i < N; i++) begin
      c.fh_x[10*i +: 10] = 10'(40 * i + seed);
      c.fh_y[10*i +: 10] = 10'(20 * i + seed);
    end
    c.ovl = ovl; c.idx = 5'(idx); c.sel = 3'(sel);
    return c;
  endfunction

  function automatic cfg_t rnd_cfg();
    cfg_t c;
    c.bl_x = 10'($urandom); c.bl_y = 10'($urandom); c.wh_x = 10'($urandom); c.wh_y = 10'($urandom);
    c.fh_x = 70'({$urandom, $urandom, $urandom});
    c.fh_y = 70'({$urandom, $urandom, $urandom});
    c.ovl = 1'($urandom); c.idx = 5'($urandom); c.sel = 3'($urandom);
    return c;
  endfunction

  // Expected draw list straight from the frame recipe
  function automatic void build_exp(input cfg_t c);
    exp_q.delete();
    for (int i = 0; i < 60; i++) exp_q.push_back(mk((i % 10) * 32, (i / 10) * 32, 0, 1'b0));
    for (int i = 0; i < N; i++) exp_q.push_back(mk(int'(c.fh_x[10*i +: 10]), int'(c.fh_y[10*i +: 10]), 2, 1'b1));
    exp_q.push_back(mk(int'(c.wh_x), int'(c.wh_y), 3, 1'b1));
    exp_q.push_back(mk(int'(c.bl_x), int'(c.bl_y), 1, 1'b1));
    if (c.ovl) begin
      exp_q.push_back(mk(144, 74, int'(c.idx), 1'b1));
      exp_q.push_back(mk(112, 74 + 8 * int'(c.sel), 6, 1'b1));
    end
  endfunction

  task automatic set_in(input cfg_t c);
    i_bl_x = c.bl_x; i_bl_y = c.bl_y; i_wh_pos_x = c.wh_x; i_wh_pos_y = c.wh_y;
    i_fh_pos_x = c.fh_x; i_fh_pos_y = c.fh_y;
    i_overlay_en = c.ovl; i_overlay_index = c.idx; i_select_pos = c.sel;
  endtask

  // Blitter model plus frame-done monitor
  always @(negedge CLK) begin
    cyc++;
    cur = {o_blit_x, o_blit_y, o_blit_sprite, o_blit_transparent};
    if (rst) begin
      i_blit_done = 1'b0;
      cnt = -1;
    end else begin
      if (o_frame_done) begin
        frames++;
        chk("frame_done_latency", 32'(cyc - last_done), 32'd1);
      end
      i_blit_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          chk("cmd_held", 32'(cur), 32'(held));
          i_blit_done = 1'b1;
          last_done = cyc;
          cnt = -1;
        end
      end
      if (o_blit_start) begin
        chk("start_while_outstanding", 32'(cnt != -1), 32'd0);
        cap_q.push_back(cur);
        held = cur;
        starts++;
        cnt = blit_delay;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
  endtask

  task automatic wait_starts(input int target);
    for (int k = 0; k < 5000 && starts < target; k++) begin
      @(posedge CLK);
      #1;
    end
    chk("wait_starts", 32'(starts >= target), 32'd1);
  endtask

  task automatic wait_frames(input int target);
    for (int k = 0; k < 5000 && frames < target; k++) begin
      @(posedge CLK);
      #1;
    end
    chk("wait_frames", 32'(frames), 32'(target));
  endtask

  // mode 0: steady inputs, 1: scramble inputs each cycle, 2: move ball x to 200 mid-pass
  task automatic run_pass(input cfg_t c, input int mode);
    int f0;
    cap_q.delete();
    build_exp(c);
    set_in(c);
    f0 = frames;
    @(posedge CLK);
    #1 i_frame_start = 1'b1;
    @(posedge CLK);
    #1 i_frame_start = 1'b0;
    for (int k = 0; k < 4000 && frames == f0; k++) begin
      @(posedge CLK);
      #1;
      if (mode == 1) set_in(rnd_cfg());
      if (mode == 2 && k == 100) i_bl_x = 10'd200;
    end
    chk("pass_frames", 32'(frames - f0), 32'd1);
    chk("pass_count", 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      chk($sformatf("cmd%0d", i), 32'(cap_q[i]), 32'(exp_q[i]));
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    int s0, f0;
    cmd_t t;
    vecs[0] = '{c: mkcfg(100, 50, 200, 100, 3, 1'b0, 0, 0), n: 69, last: mk(100, 50, 1, 1'b1), h0: mk(3, 3, 2, 1'b1)};
    vecs[1] = '{c: mkcfg(10, 20, 30, 40, 5, 1'b1, 8, 2), n: 71, last: mk(112, 90, 6, 1'b1), h0: mk(5, 5, 2, 1'b1)};
    vecs[2] = '{c: mkcfg(0, 0, 288, 148, 0, 1'b1, 31, 7), n: 71, last: mk(112, 130, 6, 1'b1), h0: mk(0, 0, 2, 1'b1)};
    vecs[3] = '{c: mkcfg(1023, 1023, 500, 600, 9, 1'b0, 4, 1), n: 69, last: mk(1023, 1023, 1, 1'b1), h0: mk(9, 9, 2, 1'b1)};

    repeat (3) @(posedge CLK);
    #1 rst = 1'b0;
    @(negedge CLK);
    chk("rst_start", 32'(o_blit_start), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_frame_done", 32'(o_frame_done), 32'd0);
    chk("rst_overrun", 32'(o_overrun_cnt), 32'd0);
    chk("rst_cmd", 32'({o_blit_x, o_blit_y, o_blit_sprite, o_blit_transparent}), 32'd0);

    // first-command latency and end-of-pass busy drop
    set_in(vecs[0].c);
    @(posedge CLK);
    #1 i_frame_start = 1'b1;
    @(posedge CLK);
    #1 i_frame_start = 1'b0;
    @(negedge CLK);
    chk("first_no_start_yet", 32'(o_blit_start), 32'd0);
    @(negedge CLK);
    chk("first_start", 32'(o_blit_start), 32'd1);
    chk("first_busy", 32'(o_busy), 32'd1);
    chk("first_cmd", 32'({o_blit_x, o_blit_y, o_blit_sprite, o_blit_transparent}), 32'(mk(0, 0, 0, 1'b0)));
    for (int k = 0; k < 4000 && !o_frame_done; k++) @(negedge CLK);
    chk("end_frame_done", 32'(o_frame_done), 32'd1);
    chk("end_busy_low", 32'(o_busy), 32'd0);
    @(posedge CLK);
    #1;

    for (int v = 0; v < 4; v++) begin
      blit_delay = 3;
      run_pass(vecs[v].c, 0);
      chk("vec_count", 32'(cap_q.size()), 32'(vecs[v].n));
      t = (cap_q.size() > 0) ? cap_q[cap_q.size() - 1] : '0;
      chk("vec_last", 32'(t), 32'(vecs[v].last));
      t = (cap_q.size() > 10) ? cap_q[10] : '0;
      chk("vec_tile11", 32'(t), 32'(mk(0, 32, 0, 1'b0)));
      t = (cap_q.size() > 60) ? cap_q[60] : '0;
      chk("vec_hole0", 32'(t), 32'(vecs[v].h0));
    end

    run_pass(mkcfg(100, 60, 50, 50, 1, 1'b0, 0, 0), 2);
    t = (cap_q.size() > 68) ? cap_q[68] : '0;
    chk("snapshot_ball_x", 32'(t.x), 32'd100);

    for (int r = 0; r < 6; r++) begin
      blit_delay = int'($urandom_range(1, 4));
      run_pass(rnd_cfg(), 1);
    end

    // final done and a new request on the same edge
    blit_delay = 3;
    do_reset();
    set_in(vecs[0].c);
    s0 = starts;
    f0 = frames;
    #0 i_frame_start = 1'b1;
    @(posedge CLK);
    #1 i_frame_start = 1'b0;
    wait_starts(s0 + 69);
    repeat (2) @(posedge CLK);
    #1 i_frame_start = 1'b1;
    @(posedge CLK);
    #1 i_frame_start = 1'b0;
    @(negedge CLK);
    chk("simul_frame_done", 32'(o_frame_done), 32'd1);
    chk("simul_busy", 32'(o_busy), 32'd1);
    chk("simul_overrun", 32'(o_overrun_cnt), 32'd1);
    wait_frames(f0 + 2);
    chk("simul_starts", 32'(starts - s0), 32'd138);

    // three overruns queue exactly one pass
    do_reset();
    s0 = starts;
    f0 = frames;
    i_frame_start = 1'b1;
    @(posedge CLK);
    #1 i_frame_start = 1'b0;
    wait_starts(s0 + 10);
    for (int p = 0; p < 3; p++) begin
      i_frame_start = 1'b1;
      @(posedge CLK);
      #1 i_frame_start = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
    end
    wait_frames(f0 + 2);
    repeat (300) @(posedge CLK);
    #1;
    chk("ovr_frames", 32'(frames - f0), 32'd2);
    chk("ovr_count", 32'(o_overrun_cnt), 32'd3);
    chk("ovr_starts", 32'(starts - s0), 32'd138);
    chk("ovr_idle", 32'(o_busy), 32'd0);

    // 300 more requests saturate the counter
    i_frame_start = 1'b1;
    repeat (301) @(posedge CLK);
    #1 i_frame_start = 1'b0;
    for (int k = 0; k < 5000 && o_busy; k++) begin
      @(posedge CLK);
      #1;
    end
    chk("sat_idle", 32'(o_busy), 32'd0);
    chk("sat_count", 32'(o_overrun_cnt), 32'd255);

    // reset during the fail-hole phase
    s0 = starts;
    set_in(vecs[0].c);
    i_frame_start = 1'b1;
    @(posedge CLK);
    #1 i_frame_start = 1'b0;
    wait_starts(s0 + 62);
    rst = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("midrst_start", 32'(o_blit_start), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_frame_done", 32'(o_frame_done), 32'd0);
    chk("midrst_overrun", 32'(o_overrun_cnt), 32'd0);
    chk("midrst_cmd", 32'({o_blit_x, o_blit_y, o_blit_sprite, o_blit_transparent}), 32'd0);
    @(posedge CLK);
    #1 rst = 1'b0;
    s0 = starts;
    repeat (20) @(posedge CLK);
    #1;
    chk("midrst_no_starts", 32'(starts - s0), 32'd0);
    run_pass(vecs[1].c, 0);
    t = (cap_q.size() > 0) ? cap_q[0] : '1;
    chk("midrst_restart_tile", 32'(t), 32'(mk(0, 0, 0, 1'b0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
